// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - condition code encoding, flag indices and condition evaluator
package cpu_pkg;

    typedef enum logic [3:0] {
        EQ = 4'h0, NE = 4'h1, CS = 4'h2, CC = 4'h3,
        MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
        HI = 4'h8, LS = 4'h9, GE = 4'hA, LT = 4'hB,
        GT = 4'hC, LE = 4'hD, AL = 4'hE, NV = 4'hF
    } cond_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    function automatic logic cond_eval(input cond_t c, input logic [3:0] f);
        logic n, z, cy, v;
        n  = f[FLAG_N];
        z  = f[FLAG_Z];
        cy = f[FLAG_C];
        v  = f[FLAG_V];
        case (c)
            EQ:      cond_eval = z;
            NE:      cond_eval = !z;
            CS:      cond_eval = cy;
            CC:      cond_eval = !cy;
            MI:      cond_eval = n;
            PL:      cond_eval = !n;
            VS:      cond_eval = v;
            VC:      cond_eval = !v;
            HI:      cond_eval = cy & !z;
            LS:      cond_eval = !cy | z;
            GE:      cond_eval = (n == v);
            LT:      cond_eval = (n != v);
            GT:      cond_eval = !z & (n == v);
            LE:      cond_eval = z | (n != v);
            AL:      cond_eval = 1'b1;
            default: cond_eval = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/flag_stack.sv
// rtl/flag_stack.sv - LIFO of saved flag vectors with sticky misuse error
module flag_stack
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  logic [3:0] wdata,
    output logic [3:0] rdata,
    output logic       full,
    output logic       empty,
    output logic       err,
    output logic       pop_ok
);
    localparam int PW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] top_ptr;
    logic [3:0]    mem [DEPTH];
    logic          push_ok;
    logic          illegal;

    assign full    = (ptr == PW'(DEPTH));
    assign empty   = (ptr == '0);
    // Simultaneous push and pop is treated as misuse rather than a swap.
    assign push_ok = push & !pop & !full;
    assign pop_ok  = pop & !push & !empty;
    assign illegal = (push | pop) & !push_ok & !pop_ok;
    assign top_ptr = ptr - PW'(1);
    assign rdata   = mem[top_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
            err <= 1'b0;
        end else begin
            if (push_ok) begin
                ptr <= ptr + PW'(1);
            end else if (pop_ok) begin
                ptr <= top_ptr;
            end
            if (illegal) begin
                err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[ptr[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/flag_cond_unit.sv
// rtl/flag_cond_unit.sv - architectural flag register, condition evaluation and flag save stack
module flag_cond_unit
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] alu_flags,
    input  logic       flag_write,
    input  logic [3:0] cond,
    input  logic       cond_valid,
    output logic       cond_ready,
    input  logic       res_ready,
    output logic       cond_pass_valid,
    output logic       cond_pass,
    input  logic       push,
    input  logic       pop,
    output logic [3:0] flags,
    output logic       stack_full,
    output logic       stack_empty,
    output logic       stack_err
);
    logic [3:0] eff;
    logic [3:0] stack_top;
    logic       pop_ok;
    logic       accept;

    // Bypass lets a condition issued with its flag-setting op see the new flags.
    assign eff        = flag_write ? alu_flags : flags;
    assign cond_ready = !cond_pass_valid | res_ready;
    assign accept     = cond_valid & cond_ready;

    flag_stack #(.DEPTH(DEPTH)) u_stack (
        .clk    (clk),
        .reset  (reset),
        .push   (push),
        .pop    (pop),
        .wdata  (eff),
        .rdata  (stack_top),
        .full   (stack_full),
        .empty  (stack_empty),
        .err    (stack_err),
        .pop_ok (pop_ok)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            flags <= 4'b0000;
        end else if (pop_ok) begin
            flags <= stack_top;
        end else if (flag_write) begin
            flags <= alu_flags;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cond_pass_valid <= 1'b0;
            cond_pass       <= 1'b0;
        end else if (accept) begin
            cond_pass_valid <= 1'b1;
            cond_pass       <= cond_eval(cond_t'(cond), eff);
        end else if (res_ready) begin
            cond_pass_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_flag_cond_unit.sv
// tb/tb_flag_cond_unit.sv - scoreboard bench for flag_cond_unit
module tb_flag_cond_unit;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] alu_flags;
    logic       flag_write;
    logic [3:0] cond;
    logic       cond_valid;
    logic       cond_ready;
    logic       res_ready;
    logic       cond_pass_valid;
    logic       cond_pass;
    logic       push;
    logic       pop;
    logic [3:0] flags;
    logic       stack_full;
    logic       stack_empty;
    logic       stack_err;

    int checks = 0;
    int errors = 0;

    logic       exp_q [$];
    logic [3:0] m_stack [$];
    logic [3:0] m_flags;
    logic       m_err;
    logic       m_cpv;
    logic       m_acc;
    logic       cr_seen;
    logic       cr_exp;

    flag_cond_unit #(.DEPTH(DEPTH)) dut (
        .clk             (clk),
        .reset           (reset),
        .alu_flags       (alu_flags),
        .flag_write      (flag_write),
        .cond            (cond),
        .cond_valid      (cond_valid),
        .cond_ready      (cond_ready),
        .res_ready       (res_ready),
        .cond_pass_valid (cond_pass_valid),
        .cond_pass       (cond_pass),
        .push            (push),
        .pop             (pop),
        .flags           (flags),
        .stack_full      (stack_full),
        .stack_empty     (stack_empty),
        .stack_err       (stack_err)
    );

    always #5 clk = ~clk;

    function automatic logic model_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'd0:    model_cond = z;
            4'd1:    model_cond = !z;
            4'd2:    model_cond = cy;
            4'd3:    model_cond = !cy;
            4'd4:    model_cond = n;
            4'd5:    model_cond = !n;
            4'd6:    model_cond = v;
            4'd7:    model_cond = !v;
            4'd8:    model_cond = cy && !z;
            4'd9:    model_cond = !cy || z;
            4'd10:   model_cond = (n == v);
            4'd11:   model_cond = (n != v);
            4'd12:   model_cond = !z && (n == v);
            4'd13:   model_cond = z || (n != v);
            4'd14:   model_cond = 1'b1;
            default: model_cond = 1'b0;
        endcase
    endfunction

    // Drives one cycle, updates the reference model and pushes expected results.
    task automatic drive(input logic fw, input logic [3:0] af, input logic cv,
                         input logic [3:0] c, input logic rr, input logic pu, input logic po);
        logic [3:0] eff;
        logic       bad;
        flag_write = fw; alu_flags = af; cond_valid = cv; cond = c;
        res_ready = rr; push = pu; pop = po;
        #1;
        cr_seen = cond_ready;
        cr_exp  = !m_cpv || rr;
        eff     = fw ? af : m_flags;
        m_acc   = cv && cr_exp;
        if (m_acc) begin
            exp_q.push_back(model_cond(c, eff));
            m_cpv = 1'b1;
        end else if (rr) begin
            m_cpv = 1'b0;
        end
        bad = (pu && po) || (pu && m_stack.size() == DEPTH) || (po && m_stack.size() == 0);
        if (bad) begin
            m_err = 1'b1;
            if (fw) m_flags = af;
        end else if (pu) begin
            m_stack.push_back(eff);
            if (fw) m_flags = af;
        end else if (po) begin
            m_flags = m_stack.pop_back();
        end else if (fw) begin
            m_flags = af;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        flag_write = 0; alu_flags = 0; cond_valid = 0; cond = 0;
        res_ready = 0; push = 0; pop = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        m_flags = 4'b0000; m_err = 0; m_cpv = 0; m_acc = 0;
        m_stack.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b exp 0000", flags); end
        checks++; if (stack_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", stack_empty); end
        checks++; if (stack_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", stack_full); end
        checks++; if (stack_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", stack_err); end
        checks++; if (cond_pass_valid !== 1'b0 || cond_pass !== 1'b0) begin errors++; $display("FAIL reset_result got %b%b exp 00", cond_pass_valid, cond_pass); end
        checks++; if (cond_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", cond_ready); end
    endtask

    task automatic test_al_nv();
        drive(0, 4'h0, 1, 4'hE, 1, 0, 0);
        checks++; if (cond_pass_valid !== 1'b1 || cond_pass !== 1'b1 || cond_pass !== exp_q[0]) begin errors++; $display("FAIL al_result got v=%b p=%b exp v=1 p=1", cond_pass_valid, cond_pass); end
        void'(exp_q.pop_front());
        drive(0, 4'h0, 1, 4'hF, 1, 0, 0);
        checks++; if (cond_pass_valid !== 1'b1 || cond_pass !== 1'b0 || cond_pass !== exp_q[0]) begin errors++; $display("FAIL nv_result got v=%b p=%b exp v=1 p=0", cond_pass_valid, cond_pass); end
        void'(exp_q.pop_front());
        drive(0, 4'h0, 0, 4'h0, 1, 0, 0);
        checks++; if (cond_pass_valid !== 1'b0) begin errors++; $display("FAIL drain_valid got %b exp 0", cond_pass_valid); end
    endtask

    task automatic test_bypass();
        drive(1, 4'b0100, 1, 4'h0, 1, 0, 0);
        checks++; if (cond_pass !== 1'b1 || cond_pass !== exp_q[0]) begin errors++; $display("FAIL bypass_eq got %b exp 1", cond_pass); end
        void'(exp_q.pop_front());
        checks++; if (flags !== 4'b0100) begin errors++; $display("FAIL bypass_flags got %b exp 0100", flags); end
        drive(1, 4'b1001, 1, 4'hA, 1, 0, 0);
        checks++; if (cond_pass !== 1'b1 || cond_pass !== exp_q[0]) begin errors++; $display("FAIL bypass_ge got %b exp 1", cond_pass); end
        void'(exp_q.pop_front());
        drive(0, 4'b0000, 1, 4'hC, 1, 0, 0);
        checks++; if (cond_pass !== 1'b1 || cond_pass !== exp_q[0]) begin errors++; $display("FAIL reg_gt got %b exp 1", cond_pass); end
        void'(exp_q.pop_front());
        checks++; if (flags !== 4'b1001) begin errors++; $display("FAIL reg_flags got %b exp 1001", flags); end
    endtask

    task automatic test_backpressure();
        drive(1, 4'b0100, 1, 4'h1, 1, 0, 0);
        checks++; if (cond_pass_valid !== 1'b1 || cond_pass !== 1'b0 || cond_pass !== exp_q[0]) begin errors++; $display("FAIL bp_first got v=%b p=%b exp v=1 p=0", cond_pass_valid, cond_pass); end
        void'(exp_q.pop_front());
        for (int i = 0; i < 3; i++) begin
            drive(0, 4'h0, 1, 4'hE, 0, 0, 0);
            checks++; if (cr_seen !== 1'b0) begin errors++; $display("FAIL bp_ready cycle %0d got %b exp 0", i, cr_seen); end
            checks++; if (cond_pass_valid !== 1'b1 || cond_pass !== 1'b0) begin errors++; $display("FAIL bp_stable cycle %0d got v=%b p=%b exp v=1 p=0", i, cond_pass_valid, cond_pass); end
        end
        drive(0, 4'h0, 1, 4'h0, 1, 0, 0);
        checks++; if (cr_seen !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b exp 1", cr_seen); end
        checks++; if (cond_pass_valid !== 1'b1 || cond_pass !== 1'b1 || exp_q.size() != 1 || cond_pass !== exp_q[0]) begin errors++; $display("FAIL bp_release got v=%b p=%b exp v=1 p=1", cond_pass_valid, cond_pass); end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        drive(0, 4'h0, 0, 4'h0, 1, 0, 0);
    endtask

    task automatic test_stack_round_trip();
        do_reset();
        drive(1, 4'b0010, 0, 4'h0, 1, 0, 0);
        drive(0, 4'h0, 0, 4'h0, 1, 1, 0);
        drive(1, 4'b1100, 0, 4'h0, 1, 0, 0);
        drive(0, 4'h0, 0, 4'h0, 1, 1, 0);
        drive(1, 4'b0001, 0, 4'h0, 1, 0, 0);
        checks++; if (flags !== 4'b0001 || stack_empty !== 1'b0) begin errors++; $display("FAIL rt_pre got flags=%b empty=%b exp 0001 0", flags, stack_empty); end
        drive(0, 4'h0, 0, 4'h0, 1, 0, 1);
        checks++; if (flags !== 4'b1100) begin errors++; $display("FAIL rt_pop1 got %b exp 1100", flags); end
        drive(0, 4'h0, 0, 4'h0, 1, 0, 1);
        checks++; if (flags !== 4'b0010 || stack_empty !== 1'b1 || stack_err !== 1'b0) begin errors++; $display("FAIL rt_pop2 got flags=%b empty=%b err=%b exp 0010 1 0", flags, stack_empty, stack_err); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            drive(1, 4'(i), 0, 4'h0, 1, 1, 0);
            checks++; if (stack_full !== (i >= 4) || stack_err !== (i == 5)) begin errors++; $display("FAIL ovf_push%0d got full=%b err=%b exp full=%b err=%b", i, stack_full, stack_err, (i >= 4), (i == 5)); end
        end
        for (int i = 4; i >= 1; i--) begin
            drive(0, 4'h0, 0, 4'h0, 1, 0, 1);
            checks++; if (flags !== 4'(i) || flags !== m_flags) begin errors++; $display("FAIL ovf_pop got %b exp %b", flags, 4'(i)); end
        end
        checks++; if (stack_empty !== 1'b1 || stack_err !== 1'b1) begin errors++; $display("FAIL ovf_drained got empty=%b err=%b exp 1 1", stack_empty, stack_err); end
        drive(0, 4'h0, 1, 4'hE, 0, 0, 0);
        do_reset();
        checks++; if (cond_pass_valid !== 1'b0 || stack_err !== 1'b0) begin errors++; $display("FAIL reset_mid got v=%b err=%b exp 0 0", cond_pass_valid, stack_err); end
        drive(0, 4'h0, 0, 4'h0, 1, 0, 1);
        checks++; if (stack_err !== 1'b1 || flags !== 4'b0000) begin errors++; $display("FAIL underflow got err=%b flags=%b exp 1 0000", stack_err, flags); end
    endtask

    task automatic test_conflict();
        do_reset();
        drive(1, 4'b0011, 0, 4'h0, 1, 1, 0);
        drive(1, 4'b1000, 1, 4'h4, 1, 0, 1);
        checks++; if (flags !== 4'b0011) begin errors++; $display("FAIL conflict_flags got %b exp 0011", flags); end
        checks++; if (cond_pass !== 1'b1 || cond_pass !== exp_q[0]) begin errors++; $display("FAIL conflict_bypass got %b exp 1", cond_pass); end
        void'(exp_q.pop_front());
        checks++; if (stack_empty !== 1'b1 || stack_err !== 1'b0) begin errors++; $display("FAIL conflict_stack got empty=%b err=%b exp 1 0", stack_empty, stack_err); end
        drive(0, 4'h0, 0, 4'h0, 1, 1, 0);
        drive(1, 4'b0110, 0, 4'h0, 1, 1, 1);
        checks++; if (stack_err !== 1'b1 || stack_empty !== 1'b0 || stack_full !== 1'b0) begin errors++; $display("FAIL pushpop got err=%b empty=%b full=%b exp 1 0 0", stack_err, stack_empty, stack_full); end
        checks++; if (flags !== 4'b0110) begin errors++; $display("FAIL pushpop_flags got %b exp 0110", flags); end
        drive(0, 4'h0, 0, 4'h0, 1, 0, 1);
        checks++; if (flags !== 4'b0011 || stack_empty !== 1'b1) begin errors++; $display("FAIL pushpop_after got flags=%b empty=%b exp 0011 1", flags, stack_empty); end
    endtask

    task automatic test_back_to_back();
        logic prev_p;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(1, 4'($urandom_range(0, 15)), 1, 4'(i), 1, 0, 0);
            checks++; if (cond_pass_valid !== 1'b1 || exp_q.size() == 0 || cond_pass !== exp_q[0]) begin errors++; $display("FAIL b2b cond %0d got v=%b p=%b flags=%b", i, cond_pass_valid, cond_pass, flags); end
            if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
        prev_p = cond_pass;
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0));
            checks++;
            if (m_acc) begin
                if (cond_pass_valid !== 1'b1 || exp_q.size() == 0 || cond_pass !== exp_q[0]) begin errors++; $display("FAIL rnd_result iter %0d got v=%b p=%b", i, cond_pass_valid, cond_pass); end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end else if (m_cpv) begin
                if (cond_pass_valid !== 1'b1 || cond_pass !== prev_p) begin errors++; $display("FAIL rnd_stall iter %0d got v=%b p=%b exp v=1 p=%b", i, cond_pass_valid, cond_pass, prev_p); end
            end else if (cond_pass_valid !== 1'b0) begin
                errors++; $display("FAIL rnd_idle iter %0d got v=%b exp 0", i, cond_pass_valid);
            end
            checks++; if (cr_seen !== cr_exp) begin errors++; $display("FAIL rnd_ready iter %0d got %b exp %b", i, cr_seen, cr_exp); end
            checks++;
            if (flags !== m_flags || stack_err !== m_err || stack_empty !== (m_stack.size() == 0) || stack_full !== (m_stack.size() == DEPTH)) begin
                errors++; $display("FAIL rnd_state iter %0d got flags=%b err=%b empty=%b full=%b exp %b %b %b %b", i, flags, stack_err, stack_empty, stack_full, m_flags, m_err, (m_stack.size() == 0), (m_stack.size() == DEPTH));
            end
            prev_p = cond_pass;
        end
    endtask

    initial begin
        test_reset();
        test_al_nv();
        test_bypass();
        test_backpressure();
        test_stack_round_trip();
        test_overflow();
        test_conflict();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
